// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arp_pkg
//  Description : Shared ARP constants, types and the transmit word mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package arp_pkg;

    localparam logic [15:0] HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  HLEN       = 8'h06;
    localparam logic [7:0]  PLEN       = 8'h04;
    localparam logic [15:0] OPER_REQ   = 16'h0001;
    localparam logic [15:0] OPER_REP   = 16'h0002;
    localparam int          ARP_WORDS  = 7;

    typedef enum logic [0:0] {
        KIND_REQUEST = 1'b0,
        KIND_REPLY   = 1'b1
    } arp_kind_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // 28-byte ARP body packed into seven big-endian 32-bit words.
    function automatic logic [31:0] arp_word(
        input logic [2:0]  idx,
        input arp_kind_t   kind,
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        logic [15:0] oper;
        logic [31:0] word;
        oper = (kind == KIND_REPLY) ? OPER_REP : OPER_REQ;
        case (idx)
            3'd0:    word = {HTYPE_ETH, PTYPE_IPV4};
            3'd1:    word = {HLEN, PLEN, oper};
            3'd2:    word = sha[47:16];
            3'd3:    word = {sha[15:0], spa[31:16]};
            3'd4:    word = {spa[15:0], tha[47:32]};
            3'd5:    word = tha[31:0];
            3'd6:    word = tpa;
            default: word = 32'h0;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arp_reply_tx.sv
`default_nettype none
// ============================================================================
//  Module      : arp_reply_tx
//  Description : Streams ARP reply/request packets as seven 32-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
module arp_reply_tx
    import arp_pkg::*;
#(
    parameter logic [47:0] MY_MAC = 48'h0010A47BEA80,
    parameter logic [31:0] MY_IP  = 32'hC0A80102
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_en,
    input  logic [31:0] send_ip_addr,
    input  logic [47:0] send_mac_addr,
    input  logic        req_en,
    input  logic [31:0] req_ip_addr,
    output logic        reply_ready,
    output logic        req_ready,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop
);

    localparam logic [2:0] C_LAST = 3'(ARP_WORDS - 1);

    tx_state_t   r_state;
    logic [2:0]  r_cnt;
    arp_kind_t   r_kind;
    logic [31:0] r_ip;
    logic [47:0] r_mac;
    logic        r_pend;
    logic [31:0] r_pend_ip;

    logic        w_idle;
    logic        w_handshake;
    logic        w_last;
    logic        w_start;
    logic        w_pend_set;
    arp_kind_t   w_start_kind;
    logic [31:0] w_start_ip;
    logic [47:0] w_start_mac;
    logic [2:0]  w_cnt_nxt;

    assign w_idle      = (r_state == ST_IDLE);
    assign reply_ready = w_idle;
    assign req_ready   = w_idle || !r_pend;

    assign w_handshake = tx_valid && tx_ready;
    assign w_last      = (r_cnt == C_LAST);
    assign w_cnt_nxt   = r_cnt + 3'd1;

    // A packet starts from IDLE on any pulse, or back-to-back after the final
    // word when a request is pending or arrives in that same cycle.
    assign w_start = w_idle ? (send_en || req_en)
                            : (w_handshake && w_last && (r_pend || req_en));

    assign w_start_kind = (w_idle && send_en) ? KIND_REPLY : KIND_REQUEST;
    assign w_start_ip   = w_idle ? (send_en ? send_ip_addr : req_ip_addr)
                                 : (r_pend ? r_pend_ip : req_ip_addr);
    assign w_start_mac  = (w_idle && send_en) ? send_mac_addr : 48'h0;

    // A request is parked when it loses to a reply or arrives mid-packet.
    assign w_pend_set = req_en && !r_pend &&
                        (w_idle ? send_en : !(w_handshake && w_last));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_kind    <= KIND_REQUEST;
            r_ip      <= '0;
            r_mac     <= '0;
            r_pend    <= 1'b0;
            r_pend_ip <= '0;
            tx_valid  <= 1'b0;
            tx_sop    <= 1'b0;
            tx_eop    <= 1'b0;
            tx_data   <= '0;
        end else begin
            if (w_start) begin
                r_state  <= ST_SEND;
                r_cnt    <= '0;
                r_kind   <= w_start_kind;
                r_ip     <= w_start_ip;
                r_mac    <= w_start_mac;
                tx_valid <= 1'b1;
                tx_sop   <= 1'b1;
                tx_eop   <= 1'b0;
                tx_data  <= arp_word(3'd0, w_start_kind, MY_MAC, MY_IP,
                                     w_start_mac, w_start_ip);
            end else if (w_handshake && w_last) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                tx_valid <= 1'b0;
                tx_sop   <= 1'b0;
                tx_eop   <= 1'b0;
                tx_data  <= '0;
            end else if (w_handshake) begin
                r_cnt   <= w_cnt_nxt;
                tx_sop  <= 1'b0;
                tx_eop  <= (w_cnt_nxt == C_LAST);
                tx_data <= arp_word(w_cnt_nxt, r_kind, MY_MAC, MY_IP, r_mac, r_ip);
            end

            if (w_pend_set) begin
                r_pend    <= 1'b1;
                r_pend_ip <= req_ip_addr;
            end else if (w_start && !w_idle) begin
                r_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/arp_reply_tx.md
ARP_REPLY_TX -- requirements
Module: arp_reply_tx

Interface
REQ-001 SHALL have parameter MY_MAC, default 48'h0010A47BEA80: local hardware address placed in SHA.
REQ-002 SHALL have parameter MY_IP, default 32'hC0A80102: local protocol address placed in SPA.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 send_en  input  1  one-cycle pulse: send an ARP reply.
REQ-006 send_ip_addr  input  32  requester IP, used as TPA of the reply.
REQ-007 send_mac_addr  input  48  requester MAC, used as THA of the reply.
REQ-008 req_en  input  1  one-cycle pulse: send an ARP request.
REQ-009 req_ip_addr  input  32  IP to resolve, used as TPA of the request.
REQ-010 reply_ready  output  1  high only in IDLE; send_en is accepted only while high.
REQ-011 req_ready  output  1  high in IDLE and while no request is pending.
REQ-012 tx_data  output  32  packet word, MSB first.
REQ-013 tx_valid  output  1  tx_data is valid.
REQ-014 tx_ready  input  1  downstream accepts the word when tx_valid and tx_ready are both high.
REQ-015 tx_sop / tx_eop  output  1 each  asserted with word 0 / word 6.

Function
REQ-016 States SHALL be IDLE and SEND, with a 3-bit word counter 0..6.
REQ-017 Capture from IDLE:
- send_en=1 latches send_ip_addr and send_mac_addr, sets kind=REPLY, and enters SEND the next cycle.
- Otherwise req_en=1 latches req_ip_addr, sets kind=REQUEST, and enters SEND.
REQ-018 Latency: tx_valid SHALL rise on the cycle after the accepted pulse, with word 0.
REQ-019 Word map (packet words 0..6):
- w0 = {16'h0001, 16'h0800}
- w1 = {8'h06, 8'h04, OPER}
- w2 = SHA[47:16]
- w3 = {SHA[15:0], SPA[31:16]}
- w4 = {SPA[15:0], THA[47:32]}
- w5 = THA[31:0]
- w6 = TPA
REQ-020 Field values:
- REPLY: OPER=16'h0002, THA=latched MAC, TPA=latched IP.
- REQUEST: OPER=16'h0001, THA=48'h0, TPA=latched request IP.
- Both: SHA=MY_MAC, SPA=MY_IP.
REQ-021 The counter SHALL advance only on tx_valid and tx_ready; while tx_ready=0, tx_data, tx_sop and tx_eop SHALL hold stable.
REQ-022 Once tx_valid is asserted, it SHALL stay high until word 6 is accepted; there are no bubbles within a packet.
REQ-023 When send_en and req_en arrive in the same IDLE cycle, the reply SHALL win and the request SHALL be latched as pending (one entry deep).
REQ-024 After word 6 is accepted:
- If a request is pending, the block SHALL start it with word 0 on the next cycle and clear pending.
- Otherwise it SHALL return to IDLE, with tx_valid=0 that cycle.
REQ-025 Pulses outside their ready window SHALL be ignored; send_en during SEND is dropped.
REQ-026 Throughput SHALL be 7 cycles per packet under continuous tx_ready, plus 1 IDLE cycle between independent packets.

Reset
REQ-027 Under reset, outputs SHALL be: tx_valid=0, tx_sop=0, tx_eop=0, tx_data=0, reply_ready=1 (combinational from IDLE), req_ready=1.
REQ-028 Reset SHALL clear state to IDLE, the counter to 0, pending to 0, and the latched addresses to 0.
REQ-029 Reset mid-packet SHALL abort the packet: tx_valid=0 on the cycle after reset is sampled, and no partial packet resumes.

Structure
REQ-030 A shared arp_pkg SHALL hold HTYPE_ETH=16'h0001, PTYPE_IPV4=16'h0800, HLEN=8'h06, PLEN=8'h04, OPER_REQ=16'h0001, OPER_REP=16'h0002, and ARP_WORDS=7; the receive path uses the same constants.
REQ-031 The block is a single module with no sub-module; the word mux is a function or case over counter and kind.

Verification
REQ-032 Reply case:
- Stimulus: send_en with IP C0A80105 and MAC 001122334455; tx_ready=1.
- Response: 7 words, w1=06040002, w4=01020011, w5=22334455, w6=C0A80105, sop on w0, eop on w6.
REQ-033 Request case:
- Stimulus: req_en with IP C0A801FE.
- Response: w1=06040001, w4[15:0]=0, w5=0, w6=C0A801FE.
REQ-034 Backpressure:
- Stimulus: tx_ready toggled 1,0,0,1,... during the packet.
- Response: each word is held stable while stalled, the packet completes in 7 handshakes, and tx_valid shows no gaps.
REQ-035 Collision:
- Stimulus: send_en and req_en in the same cycle.
- Response: the reply packet, then the request packet starting on the cycle after the reply's eop handshake; req_ready=0 between them.
REQ-036 Reset mid-packet:
- Stimulus: reset asserted after w3 is accepted.
- Response: tx_valid=0 the next cycle; reply_ready=1; a new send_en produces a complete packet starting at w0.
